word_serial_tx: RTL and testbench

- Parallel-in, serial-out transmitter for 16-bit datapath words, e.g. Q8.8 values where 16'h0100 = 1.0.
- Accepts one word per valid/ready handshake and emits it as a framed bit stream: start bit, WIDTH data bits MSB first, stop bit.
- Sits after the datapath result registers and drives a one-wire serial link toward the matching deserializer.

---
 rtl/word_serial_tx.sv | 163 ++++++++++++++++
 tb/tb_word_serial_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serial_tx.sv
// Purpose: framed parallel-to-serial transmitter (start bit, WIDTH data bits MSB first, stop bit).
// Latency: start bit appears the cycle after the accepting edge; frame lasts (WIDTH+2)*BIT_CYCLES cycles, done follows.
// Backpressure: in_ready is high only in IDLE; in_valid is ignored while a frame is in progress.
module word_serial_tx #(
    parameter int WIDTH      = 16,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    // Counter widths never drop below one bit so degenerate parameters still elaborate.
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [CYC_W-1:0] cyc_cnt;
    logic [CYC_W-1:0] cyc_nxt;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;

    logic             sout_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic             accept;
    logic             kill;
    logic             cyc_last;
    logic             bit_last;

    // Handshake is purely a decode of the state register.
    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready;

    // Abort only matters once a frame is running; in IDLE it must not block a transfer.
    assign kill     = abort & (state != IDLE);

    assign cyc_last = (cyc_cnt == CYC_LAST);
    assign bit_last = (bit_cnt == BIT_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = START;
                START:   if (cyc_last) state_nxt = DATA;
                DATA:    if (cyc_last && bit_last) state_nxt = STOP;
                STOP:    if (cyc_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values for the bit-period counter, bit index and shift register.
    always_comb begin
        cyc_nxt   = cyc_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        if (kill) begin
            cyc_nxt   = '0;
            bit_nxt   = '0;
            shreg_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    cyc_nxt = '0;
                    bit_nxt = '0;
                    if (accept) begin
                        shreg_nxt = pin;
                    end
                end
                START, STOP: begin
                    cyc_nxt = cyc_last ? '0 : cyc_cnt + CYC_W'(1);
                end
                DATA: begin
                    if (cyc_last) begin
                        // Bit boundary: present the next bit at the MSB.
                        cyc_nxt   = '0;
                        shreg_nxt = shreg << 1;
                        bit_nxt   = bit_last ? '0 : bit_cnt + BIT_W'(1);
                    end else begin
                        cyc_nxt = cyc_cnt + CYC_W'(1);
                    end
                end
                default: begin
                    cyc_nxt = '0;
                    bit_nxt = '0;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            cyc_cnt <= cyc_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // Output decode from the upcoming state, so the registered outputs line up with it.
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == STOP) && cyc_last && !kill;
        case (state_nxt)
            START:   sout_nxt = 1'b0;
            DATA:    sout_nxt = shreg_nxt[WIDTH-1];
            default: sout_nxt = 1'b1;
        endcase
    end

    // Outputs come straight from flops so the serial line and status never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sout <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            sout <= sout_nxt;
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_word_serial_tx.sv
// Testbench for word_serial_tx: directed frames with a queue-based scoreboard.
// The monitor decodes every frame on sout and checks it against the queued expectation.
module tb_word_serial_tx;

    localparam int W     = 16;
    localparam int BC    = 4;
    localparam int FRAME = (W + 2) * BC;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic [W-1:0] pin      = '0;
    logic         in_valid = 1'b0;
    logic         abort    = 1'b0;
    logic         in_ready;
    logic         sout;
    logic         busy;
    logic         done;

    logic [7:0]   pin2      = '0;
    logic         in_valid2 = 1'b0;
    logic         abort2    = 1'b0;
    logic         in_ready2;
    logic         sout2;
    logic         busy2;
    logic         done2;

    int tests         = 0;
    int fails         = 0;
    int cyc           = 0;
    int last_done_cyc = -1000;

    typedef struct {
        logic [W-1:0] word;
        bit           aborted;
        int           start_cyc;
    } exp_t;

    exp_t sb_q[$];

    word_serial_tx #(.WIDTH(W), .BIT_CYCLES(BC)) dut (
        .clk      (clk),
        .rst      (rst),
        .pin      (pin),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .abort    (abort),
        .sout     (sout),
        .busy     (busy),
        .done     (done)
    );

    word_serial_tx #(.WIDTH(8), .BIT_CYCLES(1)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .pin      (pin2),
        .in_valid (in_valid2),
        .in_ready (in_ready2),
        .abort    (abort2),
        .sout     (sout2),
        .busy     (busy2),
        .done     (done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected line level at sample i of a frame carrying word w.
    function automatic bit exp_bit(input logic [W-1:0] w, input int i);
        if (i < BC) return 1'b0;
        if (i < BC + W * BC) return w[W - 1 - (i - BC) / BC];
        return 1'b1;
    endfunction

    // Present a word at a negedge, wait for acceptance, queue the expected frame.
    task automatic send(input logic [W-1:0] w, input bit exp_abort, input bit with_abort);
        int n = 0;
        pin      = w;
        in_valid = 1'b1;
        abort    = with_abort;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept handshake", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        sb_q.push_back('{word: w, aborted: exp_abort, start_cyc: cyc});
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle timeout", 32'(n < 300), 32'd1);
    endtask

    // Monitor: collects sout while busy, closes the frame on done (complete) or busy drop (aborted).
    initial begin
        bit           samples[$];
        exp_t         e;
        int           nmis;
        logic [W-1:0] dec;
        forever begin
            @(negedge clk);
            if (busy) begin
                samples.push_back(sout);
            end else if (samples.size() != 0 || done) begin
                if (done && samples.size() == 0) begin
                    check("spurious done", 32'(done), 32'd0);
                end else if (sb_q.size() == 0) begin
                    check("unexpected frame, queue size", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("frame end kind (1=done)", 32'(done), 32'(!e.aborted));
                    nmis = 0;
                    for (int i = 0; i < samples.size() && i < FRAME; i++) begin
                        if (samples[i] != exp_bit(e.word, i)) nmis++;
                    end
                    check("frame bit mismatches", 32'(nmis), 32'd0);
                    if (done && !e.aborted) last_done_cyc = cyc;
                    if (done && !e.aborted && samples.size() == FRAME) begin
                        dec = '0;
                        for (int j = 0; j < W; j++) dec[W-1-j] = samples[BC + j * BC + BC / 2];
                        check("decoded word", 32'(dec), 32'(e.word));
                        check("busy length", 32'(samples.size()), 32'(FRAME));
                        check("done delay from start", 32'(cyc - e.start_cyc), 32'(FRAME));
                    end else if (done && !e.aborted) begin
                        check("busy length", 32'(samples.size()), 32'(FRAME));
                    end
                end
                samples.delete();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        logic [10:0] e2;
        int          acc_cyc;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check("reset sout", 32'(sout), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset sout w8", 32'(sout2), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame, Q8.8 1.0.
        send(16'h0100, 1'b0, 1'b0);
        check("start bit low", 32'(sout), 32'd0);
        check("busy in frame", 32'(busy), 32'd1);
        check("in_ready in frame", 32'(in_ready), 32'd0);
        wait_idle();

        // Back-to-back with in_valid held high; second start one cycle after done.
        send(16'hA5C3, 1'b0, 1'b0);
        send(16'hFFFF, 1'b0, 1'b0);
        acc_cyc = sb_q[sb_q.size()-1].start_cyc;
        check("b2b start after done", 32'(acc_cyc - last_done_cyc), 32'd1);
        wait_idle();

        // Handshake ignored during DATA.
        send(16'h00FF, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            pin      = 16'h1234;
            @(negedge clk);
            check("in_ready low in DATA", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        wait_idle();

        // Abort in the middle of data bit 7.
        send(16'h8001, 1'b1, 1'b0);
        repeat (33) @(negedge clk);
        check("busy before abort", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort sout", 32'(sout), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);

        // Abort coincident with a transfer in IDLE must still accept it.
        send(16'h0001, 1'b0, 1'b1);
        check("accepted with abort in idle", 32'(busy), 32'd1);
        wait_idle();

        // Asynchronous reset mid-frame, off the clock edge.
        send(16'h1234, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async reset sout", 32'(sout), 32'd1);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset done", 32'(done), 32'd0);
        check("async reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(16'h0F0F, 1'b0, 1'b0);
        wait_idle();

        // WIDTH=8, BIT_CYCLES=1 instance: 10-cycle frame, done on cycle 11.
        e2        = 11'b01000000111;
        pin2      = 8'h81;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid2 = 1'b0;
            pin2      = 8'h00;
            check($sformatf("w8 sout cycle %0d", i + 1), 32'(sout2), 32'(e2[10-i]));
            check($sformatf("w8 busy cycle %0d", i + 1), 32'(busy2), 32'(i < 10));
            check($sformatf("w8 done cycle %0d", i + 1), 32'(done2), 32'(i == 10));
        end
        @(negedge clk);
        check("w8 done single pulse", 32'(done2), 32'd0);

        repeat (5) @(negedge clk);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
